// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: ROB redirect, memory-controller refill port and dispatcher output.
// The master modport is the fetch unit's view; slave is the surrounding system's view.
interface inst_fetch_unit_if;
   logic        full_from_backend;
   logic        rollback_flag_from_rob;
   logic [31:0] target_pc_from_rob;
   logic        ena_to_mc;
   logic [31:0] addr_to_mc;
   logic        drop_flag_to_mc;
   logic        ok_flag_from_mc;
   logic [31:0] inst_from_mc;
   logic        ok_flag_to_dsp;
   logic [31:0] inst_to_dsp;
   logic [31:0] pc_to_dsp;

   modport master (
      input  full_from_backend, rollback_flag_from_rob, target_pc_from_rob,
      input  ok_flag_from_mc, inst_from_mc,
      output ena_to_mc, addr_to_mc, drop_flag_to_mc,
      output ok_flag_to_dsp, inst_to_dsp, pc_to_dsp
   );

   modport slave (
      output full_from_backend, rollback_flag_from_rob, target_pc_from_rob,
      output ok_flag_from_mc, inst_from_mc,
      input  ena_to_mc, addr_to_mc, drop_flag_to_mc,
      input  ok_flag_to_dsp, inst_to_dsp, pc_to_dsp
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: fetch PC plus a direct-mapped one-word-per-line I-cache
// refilled from the memory controller, issuing one instruction per cycle on hits.
//
// state      | meaning
// S_IDLE     | look up pc; issue on hit, raise refill request on miss
// S_WAIT_MEM | refill outstanding at r_addr, waiting for ok_flag_from_mc
module inst_fetch_unit #(
   parameter int          ICACHE_IDX_BITS = 6,
   parameter logic [31:0] RESET_PC        = 32'h0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rdy,
   inst_fetch_unit_if.master if_fu
);
   localparam int LINES = 1 << ICACHE_IDX_BITS;
   localparam int TAG_W = 32 - ICACHE_IDX_BITS - 2;

   typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

   state_t                     r_state, w_state_nxt;
   logic [31:0]                r_pc, w_pc_nxt;
   logic                       r_ena, w_ena_nxt;
   logic [31:0]                r_addr, w_addr_nxt;
   logic                       r_drop, w_drop_nxt;
   logic                       r_ok, w_ok_nxt;
   logic [31:0]                r_inst, w_inst_nxt;
   logic [31:0]                r_pcd, w_pcd_nxt;
   logic [LINES-1:0]           r_valid;
   logic [31:0]                r_line [LINES];
   logic [TAG_W-1:0]           r_tag  [LINES];

   logic [ICACHE_IDX_BITS-1:0] w_idx;
   logic [ICACHE_IDX_BITS-1:0] w_fill_idx;
   logic                       w_hit;
   logic                       w_fill;

   assign w_idx      = r_pc[ICACHE_IDX_BITS+1:2];
   assign w_fill_idx = r_addr[ICACHE_IDX_BITS+1:2];
   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == r_pc[31:ICACHE_IDX_BITS+2]);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ena_nxt   = r_ena;
      w_addr_nxt  = r_addr;
      w_drop_nxt  = 1'b0;
      w_ok_nxt    = 1'b0;
      w_inst_nxt  = r_inst;
      w_pcd_nxt   = r_pcd;
      w_fill      = 1'b0;
      if (i_rdy) begin
         if (if_fu.rollback_flag_from_rob) begin
            // a refill completing on the rollback cycle is kept; otherwise it is abandoned
            if (r_state == S_WAIT_MEM) begin
               if (if_fu.ok_flag_from_mc) w_fill     = 1'b1;
               else                       w_drop_nxt = 1'b1;
            end
            w_pc_nxt    = if_fu.target_pc_from_rob;
            w_state_nxt = S_IDLE;
            w_ena_nxt   = 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (!if_fu.full_from_backend) begin
                     if (w_hit) begin
                        w_ok_nxt   = 1'b1;
                        w_inst_nxt = r_line[w_idx];
                        w_pcd_nxt  = r_pc;
                        w_pc_nxt   = r_pc + 32'd4;
                     end else begin
                        w_ena_nxt   = 1'b1;
                        w_addr_nxt  = r_pc;
                        w_state_nxt = S_WAIT_MEM;
                     end
                  end
               end
               S_WAIT_MEM: begin
                  if (if_fu.ok_flag_from_mc) begin
                     w_fill      = 1'b1;
                     w_ena_nxt   = 1'b0;
                     w_state_nxt = S_IDLE;
                  end
               end
               default: w_state_nxt = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_valid <= '0;
         r_ena   <= 1'b0;
         r_addr  <= '0;
         r_drop  <= 1'b0;
         r_ok    <= 1'b0;
         r_inst  <= '0;
         r_pcd   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ena   <= w_ena_nxt;
         r_addr  <= w_addr_nxt;
         r_drop  <= w_drop_nxt;
         r_ok    <= w_ok_nxt;
         r_inst  <= w_inst_nxt;
         r_pcd   <= w_pcd_nxt;
         if (w_fill) r_valid[w_fill_idx] <= 1'b1;
      end
   end

   // data/tag storage carries no reset; the valid vector alone qualifies it
   always_ff @(posedge i_clk) begin
      if (i_rst && w_fill) begin
         r_line[w_fill_idx] <= if_fu.inst_from_mc;
         r_tag[w_fill_idx]  <= r_addr[31:ICACHE_IDX_BITS+2];
      end
   end

   assign if_fu.ena_to_mc       = r_ena;
   assign if_fu.addr_to_mc      = r_addr;
   assign if_fu.drop_flag_to_mc = r_drop;
   assign if_fu.ok_flag_to_dsp  = r_ok;
   assign if_fu.inst_to_dsp     = r_inst;
   assign if_fu.pc_to_dsp       = r_pcd;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: a word-address cache model predicts every
// registered output each cycle; a memory responder serves refills with random latency.
module tb_inst_fetch_unit;
   localparam int NCYC = 6000;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   cyc;
   int   n_cmp = 0;
   int   n_err = 0;

   inst_fetch_unit_if u_if ();

   inst_fetch_unit #(.ICACHE_IDX_BITS(6), .RESET_PC(32'h0)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_rdy (rdy),
      .if_fu (u_if.master)
   );

   always #5 clk = ~clk;

   // reference model state: each line remembers the full word address it holds
   logic        m_valid [64];
   logic [31:0] m_waddr [64];
   logic [31:0] m_data  [64];
   logic [31:0] m_pc;
   logic        m_wait;
   logic        e_ok, e_ena, e_drop;
   logic [31:0] e_inst, e_pcd, e_addr;
   int          ok_dut_cnt = 0, ok_mdl_cnt = 0;

   function automatic logic [31:0] memw(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0093;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 2) % 64);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic fill(input logic [31:0] a, input logic [31:0] d);
      m_valid[line_of(a)] = 1'b1;
      m_waddr[line_of(a)] = a;
      m_data[line_of(a)]  = d;
   endtask

   task automatic model_step();
      if (!rst) begin
         m_pc = 32'h0; m_wait = 1'b0;
         e_ok = 1'b0; e_ena = 1'b0; e_drop = 1'b0;
         e_inst = '0; e_pcd = '0; e_addr = '0;
         for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      end else if (!rdy) begin
         e_ok = 1'b0; e_drop = 1'b0;
      end else begin
         e_ok = 1'b0; e_drop = 1'b0;
         if (u_if.rollback_flag_from_rob) begin
            if (m_wait) begin
               if (u_if.ok_flag_from_mc) fill(e_addr, u_if.inst_from_mc);
               else                      e_drop = 1'b1;
            end
            m_pc = u_if.target_pc_from_rob; m_wait = 1'b0; e_ena = 1'b0;
         end else if (!m_wait) begin
            if (!u_if.full_from_backend) begin
               if (m_valid[line_of(m_pc)] && m_waddr[line_of(m_pc)] == m_pc) begin
                  e_ok = 1'b1; e_inst = m_data[line_of(m_pc)]; e_pcd = m_pc;
                  m_pc = m_pc + 32'd4;
               end else begin
                  e_ena = 1'b1; e_addr = m_pc; m_wait = 1'b1;
               end
            end
         end else if (u_if.ok_flag_from_mc) begin
            fill(e_addr, u_if.inst_from_mc);
            e_ena = 1'b0; m_wait = 1'b0;
         end
      end
      if (e_ok) ok_mdl_cnt++;
   endtask

   initial begin
      bit          pending = 1'b0;
      int          lat = 0;
      bit          directed;
      rst = 1'b0; rdy = 1'b1;
      u_if.full_from_backend = 1'b0;
      u_if.rollback_flag_from_rob = 1'b0;
      u_if.target_pc_from_rob = '0;
      u_if.ok_flag_from_mc = 1'b0;
      u_if.inst_from_mc = '0;
      cyc = 0;
      @(posedge clk);
      model_step();
      @(posedge clk);
      model_step();
      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         chk("ok_to_dsp",   {31'b0, u_if.ok_flag_to_dsp},  {31'b0, e_ok});
         chk("inst_to_dsp", u_if.inst_to_dsp,              e_inst);
         chk("pc_to_dsp",   u_if.pc_to_dsp,                e_pcd);
         chk("ena_to_mc",   {31'b0, u_if.ena_to_mc},       {31'b0, e_ena});
         chk("addr_to_mc",  u_if.addr_to_mc,               e_addr);
         chk("drop_to_mc",  {31'b0, u_if.drop_flag_to_mc}, {31'b0, e_drop});
         if (u_if.ok_flag_to_dsp) ok_dut_cnt++;

         directed = (cyc < 24);
         if (directed) begin
            rst = 1'b1; rdy = 1'b1;
            u_if.full_from_backend = 1'b0;
            u_if.rollback_flag_from_rob = 1'b0;
         end else begin
            rst = ($urandom_range(0, 249) != 0);
            rdy = ($urandom_range(0, 15) != 0);
            u_if.full_from_backend = ($urandom_range(0, 3) == 0);
            u_if.rollback_flag_from_rob = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0)
               u_if.target_pc_from_rob = 32'hFFFF_FFF8;
            else
               u_if.target_pc_from_rob = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
         end

         if (!u_if.ena_to_mc) pending = 1'b0;
         u_if.ok_flag_from_mc = 1'b0;
         u_if.inst_from_mc = $urandom;
         if (u_if.ena_to_mc) begin
            if (!pending) begin
               pending = 1'b1;
               lat = directed ? 2 : $urandom_range(0, 4);
            end
            if (lat == 0) begin
               u_if.ok_flag_from_mc = 1'b1;
               u_if.inst_from_mc = memw(u_if.addr_to_mc);
               pending = 1'b0;
            end else begin
               lat--;
            end
         end else if (!directed && $urandom_range(0, 24) == 0) begin
            u_if.ok_flag_from_mc = 1'b1;
         end

         @(posedge clk);
         model_step();
      end
      @(negedge clk);
      chk("ok_pulse_total", ok_dut_cnt, ok_mdl_cnt);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
